// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory store buffer.
// Optional forwarding is selected by DMEM_WBUF_RAW_FWD_EN (see dmem_wbuf).
package dmem_pkg;

    localparam int unsigned WBUF_DEPTH = 4;
    localparam int unsigned RAM_WORDS  = 64;
    localparam int unsigned WORD_ADR_W = 6;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned PTR_W      = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef struct packed {
        logic [WORD_ADR_W-1:0] adr;
        logic [DATA_W-1:0]     data;
        logic [BE_W-1:0]       byteEn;
    } wbufEntry_t;

endpackage

// File: rtl/dmem_wbuf_if.sv
// M-stage memory request/response bundle between pipeline and dmem_wbuf.
interface dmem_wbuf_if;
    import dmem_pkg::*;

    logic              memwrite;
    logic              memread;
    logic [31:0]       dataadr;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byte_en;
    logic [DATA_W-1:0] readdata;
    logic              mem_stall;
    logic [CNT_W-1:0]  wbuf_count;
    logic              wbuf_empty;

    modport master (
        output memwrite, memread, dataadr, writedata, byte_en,
        input  readdata, mem_stall, wbuf_count, wbuf_empty
    );

    modport slave (
        input  memwrite, memread, dataadr, writedata, byte_en,
        output readdata, mem_stall, wbuf_count, wbuf_empty
    );

endinterface

// File: rtl/dmem_wbuf_fifo.sv
// In-order store buffer: entry storage, wrapping pointers and occupancy count.
// Exposes all slots ordered oldest-first so the parent can match/merge loads.
module dmem_wbuf_fifo
    import dmem_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  wbufEntry_t                        pushEntry,
    input  logic                              pop,
    output wbufEntry_t                        popEntry,
    output logic [CNT_W-1:0]                  count,
    output wbufEntry_t [WBUF_DEPTH-1:0]       ageEntry,
    output logic [WBUF_DEPTH-1:0]             ageValid
);

    wbufEntry_t [WBUF_DEPTH-1:0] slots;
    logic [PTR_W-1:0]            wrPtr;
    logic [PTR_W-1:0]            rdPtr;

    // Pointers wrap naturally at PTR_W bits; count tracks net push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                slots[wrPtr] <= pushEntry;
                wrPtr        <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign popEntry = slots[rdPtr];

    always_comb begin
        ageEntry = '0;
        ageValid = '0;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            ageEntry[i] = slots[rdPtr + PTR_W'(i)];
            ageValid[i] = CNT_W'(i) < count;
        end
    end

endmodule

// File: rtl/dmem_wbuf.sv
// Data memory (64 words) fronted by a 4-entry store buffer that drains on idle/stalled cycles.
// DMEM_WBUF_RAW_FWD_EN: forward buffered bytes to loads; otherwise stall loads that hit the buffer.
module dmem_wbuf
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    dmem_wbuf_if.slave  bus
);

    logic                        validWrite;
    logic                        validRead;
    logic                        isIdle;
    logic                        writeStall;
    logic                        readStall;
    logic                        memStall;
    logic                        doDrain;
    logic                        doEnq;
    logic [WORD_ADR_W-1:0]       reqAdr;
    logic                        unusedAdrBits;
    wbufEntry_t                  enqEntry;
    wbufEntry_t                  drainEntry;
    wbufEntry_t [WBUF_DEPTH-1:0] ageEntry;
    logic [WBUF_DEPTH-1:0]       ageValid;
    logic [WBUF_DEPTH-1:0]       hit;
    logic [CNT_W-1:0]            count;
    logic [DATA_W-1:0]           ram [RAM_WORDS];
    logic [DATA_W-1:0]           ramWord;
    logic [DATA_W-1:0]           loadData;

    // Simultaneous read and write is illegal and behaves as an idle cycle.
    assign validWrite    = bus.memwrite & ~bus.memread;
    assign validRead     = bus.memread & ~bus.memwrite;
    assign isIdle        = ~validWrite & ~validRead;
    assign reqAdr        = bus.dataadr[WORD_ADR_W+1:2];
    assign unusedAdrBits = ^{bus.dataadr[31:WORD_ADR_W+2], bus.dataadr[1:0]};
    assign enqEntry      = '{adr: reqAdr, data: bus.writedata, byteEn: bus.byte_en};

    dmem_wbuf_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (doEnq),
        .pushEntry (enqEntry),
        .pop       (doDrain),
        .popEntry  (drainEntry),
        .count     (count),
        .ageEntry  (ageEntry),
        .ageValid  (ageValid)
    );

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            hit[i] = ageValid[i] && (ageEntry[i].adr == reqAdr);
        end
    end

    assign ramWord = ram[reqAdr];

`ifdef DMEM_WBUF_RAW_FWD_EN
    // Oldest-to-youngest overlay so the youngest matching lane wins.
    always_comb begin
        loadData = ramWord;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (hit[i] && ageEntry[i].byteEn[b]) begin
                    loadData[8*b +: 8] = ageEntry[i].data[8*b +: 8];
                end
            end
        end
    end
    assign readStall = 1'b0;
`else
    assign loadData  = ramWord;
    assign readStall = validRead & (|hit);
`endif

    assign writeStall = validWrite & (count == CNT_W'(WBUF_DEPTH));
    assign memStall   = writeStall | readStall;
    assign doDrain    = (count != '0) & (isIdle | memStall);
    assign doEnq      = validWrite & ~writeStall;

    // RAM is intentionally not reset; only the drained entry's enabled lanes update.
    always_ff @(posedge clk) begin
        if (doDrain) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (drainEntry.byteEn[b]) begin
                    ram[drainEntry.adr][8*b +: 8] <= drainEntry.data[8*b +: 8];
                end
            end
        end
    end

    assign bus.readdata   = (validRead & ~rst) ? loadData : '0;
    assign bus.mem_stall  = memStall & ~rst;
    assign bus.wbuf_count = count;
    assign bus.wbuf_empty = (count == '0);

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf; expectations follow DMEM_WBUF_RAW_FWD_EN when defined.
module tb_dmem_wbuf;

    logic clk;
    logic rst;

    dmem_wbuf_if bus ();

    dmem_wbuf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mw;
        logic        mr;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] expRd;
        logic        expStall;
        logic [2:0]  expCount;
        bit          chkRd;
    } vec_t;

    vec_t        tbl[$];
    vec_t        sbQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] lastVal[int];

    function automatic vec_t mk(logic mw, logic mr, int a, logic [31:0] wd, logic [3:0] be,
                                logic [31:0] rd, logic st, int cnt, bit chkRd);
        vec_t v;
        v.mw = mw; v.mr = mr; v.adr = 32'(a); v.wd = wd; v.be = be;
        v.expRd = rd; v.expStall = st; v.expCount = 3'(cnt); v.chkRd = chkRd;
        return v;
    endfunction

    function automatic vec_t S(int a, logic [31:0] wd, logic [3:0] be, int cnt, logic st);
        return mk(1'b1, 1'b0, a, wd, be, 32'h0, st, cnt, 1'b1);
    endfunction

    function automatic vec_t L(int a, logic [31:0] rd, int cnt, logic st, bit chkRd);
        return mk(1'b0, 1'b1, a, 32'h0, 4'h0, rd, st, cnt, chkRd);
    endfunction

    function automatic vec_t I(int cnt);
        return mk(1'b0, 1'b0, 0, 32'h0, 4'h0, 32'h0, 1'b0, cnt, 1'b1);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(logic mw, logic mr, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
        bus.memwrite  = mw;
        bus.memread   = mr;
        bus.dataadr   = a;
        bus.writedata = wd;
        bus.byte_en   = be;
    endtask

    // Drive on the falling edge, queue the expectation, compare once outputs settle.
    task automatic step(vec_t v, string tag);
        vec_t e;
        @(negedge clk);
        drive(v.mw, v.mr, v.adr, v.wd, v.be);
        sbQ.push_back(v);
        #1;
        e = sbQ.pop_front();
        if (e.chkRd) chk({tag, "_readdata"}, bus.readdata, e.expRd);
        chk({tag, "_mem_stall"}, 32'(bus.mem_stall), 32'(e.expStall));
        chk({tag, "_wbuf_count"}, 32'(bus.wbuf_count), 32'(e.expCount));
        chk({tag, "_wbuf_empty"}, 32'(bus.wbuf_empty), 32'(e.expCount == 3'd0));
    endtask

    task automatic drainAll(string tag);
        for (int i = 0; i < 8 && bus.wbuf_count != 3'd0; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
        end
        chk({tag, "_drained_empty"}, 32'(bus.wbuf_empty), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int adrs[10];

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("reset_count", 32'(bus.wbuf_count), 32'd0);
        chk("reset_empty", 32'(bus.wbuf_empty), 32'd1);
        chk("reset_stall", 32'(bus.mem_stall), 32'd0);
        chk("reset_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Store 7 then load the same word.
        tbl.push_back(S(84, 32'd7, 4'hF, 0, 1'b0));
`ifdef DMEM_WBUF_RAW_FWD_EN
        tbl.push_back(L(84, 32'd7, 1, 1'b0, 1'b1));
        tbl.push_back(I(1));
`else
        tbl.push_back(L(84, 32'd0, 1, 1'b1, 1'b0));
        tbl.push_back(L(84, 32'd7, 0, 1'b0, 1'b1));
`endif
        tbl.push_back(I(0));
        // Illegal read+write is idle: nothing enqueued, no read data.
        tbl.push_back(mk(1'b1, 1'b1, 84, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0, 1'b1));
        tbl.push_back(L(86, 32'd7, 0, 1'b0, 1'b1));
        // Byte merge against RAM.
        tbl.push_back(S(84, 32'h1122_3344, 4'hF, 0, 1'b0));
        tbl.push_back(I(1));
        tbl.push_back(S(84, 32'hAABB_CCDD, 4'b0101, 0, 1'b0));
`ifdef DMEM_WBUF_RAW_FWD_EN
        tbl.push_back(L(84, 32'h11BB_33DD, 1, 1'b0, 1'b1));
        tbl.push_back(I(1));
`else
        tbl.push_back(L(84, 32'h0, 1, 1'b1, 1'b0));
        tbl.push_back(L(84, 32'h11BB_33DD, 0, 1'b0, 1'b1));
`endif
        tbl.push_back(L(84, 32'h11BB_33DD, 0, 1'b0, 1'b1));
        // Two entries to one word: youngest lane wins.
        tbl.push_back(S(88, 32'h0000_0001, 4'hF, 0, 1'b0));
        tbl.push_back(S(88, 32'h2200_0000, 4'b1000, 1, 1'b0));
`ifdef DMEM_WBUF_RAW_FWD_EN
        tbl.push_back(L(88, 32'h2200_0001, 2, 1'b0, 1'b1));
        tbl.push_back(I(2));
        tbl.push_back(I(1));
`else
        tbl.push_back(L(88, 32'h0, 2, 1'b1, 1'b0));
        tbl.push_back(L(88, 32'h0, 1, 1'b1, 1'b0));
        tbl.push_back(L(88, 32'h2200_0001, 0, 1'b0, 1'b1));
`endif
        tbl.push_back(L(88, 32'h2200_0001, 0, 1'b0, 1'b1));
        // Five back-to-back stores: fifth stalls once, then retried.
        tbl.push_back(S(80, 32'hC000_0050, 4'hF, 0, 1'b0));
        tbl.push_back(S(84, 32'hC000_0054, 4'hF, 1, 1'b0));
        tbl.push_back(S(88, 32'hC000_0058, 4'hF, 2, 1'b0));
        tbl.push_back(S(92, 32'hC000_005C, 4'hF, 3, 1'b0));
        tbl.push_back(S(96, 32'hC000_0060, 4'hF, 4, 1'b1));
        tbl.push_back(S(96, 32'hC000_0060, 4'hF, 3, 1'b0));
        tbl.push_back(I(4));
        tbl.push_back(I(3));
        tbl.push_back(I(2));
        tbl.push_back(I(1));
        tbl.push_back(I(0));
        for (int a = 80; a <= 96; a += 4) begin
            tbl.push_back(L(a, 32'hC000_0000 + 32'(a), 0, 1'b0, 1'b1));
        end

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Reset with two stores pending: they are discarded, RAM keeps old data.
        step(S(80, 32'hDEAD_0001, 4'hF, 0, 1'b0), "rstseq_st0");
        step(S(88, 32'hDEAD_0002, 4'hF, 1, 1'b0), "rstseq_st1");
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd80, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        chk("rstmid_count", 32'(bus.wbuf_count), 32'd0);
        chk("rstmid_empty", 32'(bus.wbuf_empty), 32'd1);
        chk("rstmid_stall", 32'(bus.mem_stall), 32'd0);
        chk("rstmid_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(L(80, 32'hC000_0050, 0, 1'b0, 1'b1), "rstseq_ld80");
        step(L(88, 32'hC000_0058, 0, 1'b0, 1'b1), "rstseq_ld88");

        // Ten stores with idle gaps; pointers wrap, same-address order kept.
        adrs = '{100, 104, 100, 108, 112, 104, 116, 100, 120, 124};
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(S(adrs[i], 32'h5000_0000 + 32'(i), 4'hF, cnt, 1'b0), $sformatf("wrap_st%0d", i));
            cnt++;
            lastVal[adrs[i]] = 32'h5000_0000 + 32'(i);
            if (i % 2 == 1) begin
                step(I(cnt), $sformatf("wrap_idleA%0d", i));
                cnt--;
                step(I(cnt), $sformatf("wrap_idleB%0d", i));
                cnt--;
            end
        end
        drainAll("wrap");
        foreach (lastVal[k]) begin
            step(L(k, lastVal[k], 0, 1'b0, 1'b1), $sformatf("wrap_ld%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
